irq_controller: RTL and testbench

- Memory-mapped interrupt controller that sequences external interrupt requests into the CPU's single IRQ input.
- Edge-detects up to NSRC sources (timer, UART RX, UART TX, switch), latches them as pending, applies a mask and fixed priority, and holds IRQ until the CPU enters supervisor mode (PC[31] rises).
- Tracks the in-service source until kernel code writes ACK.
- Sits on the CPU data bus next to the peripheral block; its rdata is muxed into the load path when addr falls in its window.

---
 rtl/irq_controller.sv | 102 ++++++++++
 tb/tb_irq_controller.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// irq_controller: edge-detects sources, latches pending, masks, prioritises and sequences one CPU IRQ
// Ports: clk/reset (async, active-high); rd/wr/addr/wdata/rdata bus slave at BASE..BASE+0x0C;
//        src_irq raw source levels; supervisor = PC[31]; irqout request to CPU; in_service while serviced.
module irq_controller #(
   parameter int          NSRC = 4,
   parameter logic [31:0] BASE = 32'h40000030
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rd,
   input  logic            wr,
   input  logic [31:0]     addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   input  logic [NSRC-1:0] src_irq,
   input  logic            supervisor,
   output logic            irqout,
   output logic            in_service
);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
   state_t state_q, state_d;
   logic [NSRC-1:0] pending_q, pending_d, mask_q, mask_d, src_prev_q;
   logic [NSRC-1:0] active, rise, w1c, sel_oh;
   logic [2:0] cause_id_q, cause_id_d, sel;
   logic irqout_q, irqout_d, in_service_q, in_service_d, sup_prev_q;
   logic in_win, wr_hit, ack, go_svc;
   logic unused_ok;
   assign unused_ok = ^{addr[1:0], wdata};
   assign in_win = addr[31:4] == BASE[31:4];
   assign wr_hit = wr && in_win;
   assign ack    = wr_hit && addr[3:2] == 2'd3;
   assign w1c    = (wr_hit && addr[3:2] == 2'd0) ? wdata[NSRC-1:0] : '0;
   assign rise   = src_irq & ~src_prev_q;
   assign active = pending_q & mask_q;
   assign sel_oh = active & (~active + 1'b1);
   always_comb begin
      sel = '0;
      for (int i = NSRC - 1; i >= 0; i--)
         if (active[i]) sel = 3'(i);
   end
   always_comb begin
      state_d      = state_q;
      irqout_d     = irqout_q;
      in_service_d = in_service_q;
      cause_id_d   = cause_id_q;
      go_svc       = 1'b0;
      case (state_q)
         IDLE:
            if (|active && !supervisor) begin
               state_d  = REQ;
               irqout_d = 1'b1;
            end
         REQ:
            if (!(|active)) begin
               state_d  = IDLE;
               irqout_d = 1'b0;
            end else if (supervisor && !sup_prev_q) begin
               state_d      = SERVICE;
               irqout_d     = 1'b0;
               in_service_d = 1'b1;
               cause_id_d   = sel;
               go_svc       = 1'b1;
            end
         SERVICE:
            if (ack) begin
               state_d      = IDLE;
               in_service_d = 1'b0;
            end
         default: state_d = IDLE;
      endcase
   end
   // A rising source always wins over a same-edge software or service clear.
   assign pending_d = (pending_q & ~w1c & ~(go_svc ? sel_oh : '0)) | rise;
   assign mask_d    = (wr_hit && addr[3:2] == 2'd1) ? wdata[NSRC-1:0] : mask_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         mask_q       <= '0;
         src_prev_q   <= '0;
         cause_id_q   <= '0;
         irqout_q     <= 1'b0;
         in_service_q <= 1'b0;
         sup_prev_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         src_prev_q   <= src_irq;
         cause_id_q   <= cause_id_d;
         irqout_q     <= irqout_d;
         in_service_q <= in_service_d;
         sup_prev_q   <= supervisor;
      end
   end
   assign irqout     = irqout_q;
   assign in_service = in_service_q;
   assign rdata = !(rd && in_win)  ? 32'd0 :
                  addr[3:2] == 2'd0 ? 32'(pending_q) :
                  addr[3:2] == 2'd1 ? 32'(mask_q) :
                  addr[3:2] == 2'd2 ? {in_service_q, 28'd0, cause_id_q} : 32'd0;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: table-driven directed check of irq_controller plus reset and kernel-hold sequences
module tb_irq_controller;
   localparam logic [31:0] P = 32'h40000030, M = P + 4, C = P + 8, A = P + 12;
   logic clk = 0, reset = 1, rd = 0, wr = 0, supervisor = 0;
   logic [31:0] addr = 0, wdata = 0;
   logic [3:0] src_irq = 0;
   logic [31:0] rdata;
   logic irqout, in_service;
   int nvec = 0, nbad = 0;
   typedef struct {
      logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] src; logic sup;
      logic [31:0] erd; logic eirq; logic esvc;
   } vec_t;
   vec_t v[$];
   irq_controller #(.NSRC(4), .BASE(32'h40000030)) dut (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
      .src_irq(src_irq), .supervisor(supervisor), .irqout(irqout), .in_service(in_service));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      nvec++;
      if (a !== e) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask
   function automatic void add(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] s, input logic sp, input logic [31:0] er,
                               input logic ei, input logic es);
      v.push_back('{r, w, a, wd, s, sp, er, ei, es});
   endfunction
   task automatic rchk(input string n, input logic [31:0] a, input logic [31:0] e);
      rd = 1; addr = a; #1;
      chk(n, rdata, e);
      rd = 0;
   endtask
   task automatic wreg(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk); wr = 1; addr = a; wdata = d;
      @(negedge clk); wr = 0;
   endtask
   initial begin
      // rd wr addr wdata src sup | rdata irq svc (outputs seen before the edge that follows)
      add(1,0,P,0,4'h0,0, 32'h0,0,0);
      add(1,0,M,0,4'h0,0, 32'h0,0,0);
      add(0,1,M,32'h4,4'h0,0, 32'h0,0,0);
      add(1,0,M,0,4'h0,0, 32'h4,0,0);
      add(1,0,P,0,4'h4,0, 32'h0,0,0);
      add(1,0,P,0,4'h4,0, 32'h4,0,0);
      add(1,0,P,0,4'h4,0, 32'h4,1,0);
      add(1,0,P,0,4'h4,1, 32'h4,1,0);
      add(1,0,P,0,4'h4,1, 32'h0,0,1);
      add(1,0,C,0,4'h4,1, 32'h80000002,0,1);
      add(0,1,A,0,4'h4,1, 32'h0,0,1);
      add(1,0,C,0,4'h4,1, 32'h00000002,0,0);
      add(1,0,P,0,4'h0,0, 32'h0,0,0);
      add(0,1,M,32'hF,4'h0,0, 32'h0,0,0);
      add(1,0,P,0,4'hA,0, 32'h0,0,0);
      add(1,0,P,0,4'hA,0, 32'hA,0,0);
      add(1,0,P,0,4'hA,1, 32'hA,1,0);
      add(1,0,C,0,4'hA,1, 32'h80000001,0,1);
      add(1,0,P,0,4'h0,1, 32'h8,0,1);
      add(0,1,A,0,4'h0,1, 32'h0,0,1);
      add(1,0,P,0,4'h0,0, 32'h8,0,0);
      add(1,0,P,0,4'h0,0, 32'h8,1,0);
      add(1,0,P,0,4'h0,1, 32'h8,1,0);
      add(1,0,C,0,4'h0,1, 32'h80000003,0,1);
      add(0,1,A,0,4'h0,1, 32'h0,0,1);
      add(1,0,C,0,4'h0,1, 32'h00000003,0,0);
      add(0,1,M,32'h1,4'h0,0, 32'h0,0,0);
      add(1,0,P,0,4'h4,0, 32'h0,0,0);
      add(1,0,P,0,4'h4,0, 32'h4,0,0);
      add(1,0,P,0,4'h4,0, 32'h4,0,0);
      add(1,0,P,0,4'h5,0, 32'h4,0,0);
      add(1,0,P,0,4'h5,0, 32'h5,0,0);
      add(0,1,P,32'h1,4'h5,0, 32'h0,1,0);
      add(1,0,P,0,4'h5,0, 32'h4,1,0);
      add(1,0,P,0,4'h5,0, 32'h4,0,0);
      add(0,1,P,32'h6,4'h7,0, 32'h0,0,0);
      add(1,0,P,0,4'h7,0, 32'h2,0,0);
      add(1,0,P+32'h10,0,4'h7,0, 32'h0,0,0);
      add(1,0,A,0,4'h7,0, 32'h0,0,0);
      add(0,1,P,32'h2,4'h0,0, 32'h0,0,0);
      add(1,0,P,0,4'h0,0, 32'h0,0,0);
      #1;
      chk("reset irqout", {31'd0, irqout}, 0);
      chk("reset in_service", {31'd0, in_service}, 0);
      @(negedge clk); reset = 0;
      foreach (v[i]) begin
         @(negedge clk);
         rd = v[i].rd; wr = v[i].wr; addr = v[i].addr; wdata = v[i].wdata;
         src_irq = v[i].src; supervisor = v[i].sup;
         #1;
         chk($sformatf("v%0d rdata", i), rdata, v[i].erd);
         chk($sformatf("v%0d irqout", i), {31'd0, irqout}, {31'd0, v[i].eirq});
         chk($sformatf("v%0d in_service", i), {31'd0, in_service}, {31'd0, v[i].esvc});
      end
      // Reset in the middle of a request: outputs and registers clear without a clock edge.
      @(negedge clk); rd = 0; wr = 0; src_irq = 4'h1;
      @(negedge clk);
      @(negedge clk); #1;
      chk("midreq irqout", {31'd0, irqout}, 1);
      reset = 1; src_irq = 0; #1;
      chk("async reset irqout", {31'd0, irqout}, 0);
      chk("async reset in_service", {31'd0, in_service}, 0);
      rchk("async reset PEND", P, 0);
      rchk("async reset MASK", M, 0);
      @(negedge clk); reset = 0;
      wreg(M, 32'hF);
      rchk("MASK readback", M, 32'hF);
      wreg(M, 32'hFFFFFFF1);
      rchk("MASK upper ignored", M, 32'h1);
      // Kernel-mode hold, then a level held high across service sets pending only once.
      @(negedge clk); supervisor = 1; src_irq = 4'h1;
      repeat (3) begin
         @(negedge clk); #1;
         chk("kernel hold irqout", {31'd0, irqout}, 0);
      end
      rchk("kernel hold PEND", P, 32'h1);
      @(negedge clk); supervisor = 0; #1;
      chk("pre-drop irqout", {31'd0, irqout}, 0);
      @(negedge clk);
      @(negedge clk); #1;
      chk("post-drop irqout", {31'd0, irqout}, 1);
      supervisor = 1;
      @(negedge clk); #1;
      chk("held svc irqout", {31'd0, irqout}, 0);
      chk("held svc in_service", {31'd0, in_service}, 1);
      rchk("held svc PEND", P, 0);
      rchk("held svc CAUSE", C, 32'h80000000);
      @(negedge clk); wr = 1; addr = A; wdata = 32'hDEAD;
      @(negedge clk); wr = 0; supervisor = 0;
      repeat (3) begin
         @(negedge clk); #1;
         chk("level held irqout", {31'd0, irqout}, 0);
         chk("level held in_service", {31'd0, in_service}, 0);
         rchk("level held PEND", P, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
   initial begin
      #50000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
endmodule
